mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing arbiter for the single shared memory port (memEnable / RW / MOC handshake) of the multicycle CPU. It serves two requesters: the instruction-fetch path (control states 1–3) and the data load/store path (control states 7–9). It grants the port to one requester at a time using round-robin, holds memEnable until MOC returns, registers read data, and pulses a per-requester done. An optional watchdog aborts transfers whose MOC never arrives.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, BUSY cycles without MOC before abort (watchdog build only)
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-low; sampled on posedge clk
- if_req, dm_req  in  1  transfer request; held high until matching done
- if_rw, dm_rw  in  1  0 = read, 1 = write (same meaning as RW)
- if_size, dm_size  in  2  00 byte, 01 half, 10 word
- if_addr, dm_addr  in  ADDR_W  byte address
- if_wdata, dm_wdata  in  DATA_W  write data
- if_grant, dm_grant  out  1  high while that requester owns the port (BUSY and DONE)
- if_done, dm_done  out  1  one-cycle completion pulse
- if_err, dm_err  out  1  one-cycle pulse with done on a watchdog abort
- rdata  out  DATA_W  registered read data; valid while done is high
- memEnable  out  1  memory strobe
- RW  out  1  to memory
- mem_size  out  2
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- MOC  in  1  memory operation complete
- mem_rdata  in  DATA_W

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req is high, run the round-robin pick, latch the winner's rw/size/addr/wdata into the memory-side registers, set owner, and go to BUSY. Otherwise stay in IDLE.
- BUSY: memEnable=1 and the latched fields drive the memory outputs.
  - If MOC=1 at an edge: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE: memEnable=0, owner's done=1. At the next edge:
  - If the non-owner's req is high, grant it and go directly to BUSY. This is the back-to-back case.
  - Otherwise go to IDLE.
  - The owner's req is ignored during the DONE cycle.
- Round-robin: a last-owner bit records the most recent grant.
  - On a tie, the requester that was not last owner wins.
  - With a single request, that requester wins regardless of the bit.
- Memory-side outputs are stable for the whole of BUSY. Requester inputs may change after grant without effect.
- Reset (reset=0 at an edge), including mid-transfer:
  - state→IDLE, memEnable=0, RW=0, mem_size=0, mem_addr=0, mem_wdata=0, rdata=0, all grant/done/err=0.
  - Last-owner is set to data, so fetch wins the first tie.
  - An aborted transfer produces no done.

## Timing
- Request seen at edge N → BUSY during cycle N+1 (memEnable high, grant high).
- MOC sampled high at edge M → DONE during cycle M+1 (done, rdata valid) → IDLE or BUSY at M+2.
- Minimum latency: req-high edge to done cycle is 2 cycles when MOC is already high at the first BUSY edge.
- MOC is ignored outside BUSY.
- Back-to-back alternating transfers: 1 DONE cycle between BUSY phases, no IDLE cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter ($clog2(TIMEOUT+1) bits) clears on entering BUSY and increments each BUSY cycle without MOC.
  - When it reaches TIMEOUT, go to DONE with the owner's done=1 and err=1; rdata is forced to 0 for reads.
  - MOC arriving on the same edge the count reaches TIMEOUT wins: normal completion, no err.
- MEM_ARB_TIMEOUT_EN undefined: BUSY waits for MOC indefinitely; if_err and dm_err are tied to 0; no counter exists.

## Structure
- mem_arb_pkg contains:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - owner encoding (OWN_IF=1'b0, OWN_DM=1'b1)
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
- Sub-module mem_arb_rr_picker: combinational 2-way round-robin pick. Inputs: two reqs, last-owner, exclude mask used in DONE. Outputs: valid, winner.

## Test plan
- Fetch only: if_req=1, addr 0x00000004, MOC returns 3 BUSY cycles later with 0x8C220010 → memEnable high exactly during BUSY, if_done one cycle, rdata=0x8C220010, RW=0.
- Simultaneous req right after reset → fetch granted first; dm granted straight from DONE with no IDLE cycle; last-owner=data afterwards.
- Data write: dm_rw=1, size 10, addr 0x100, wdata 0xCAFEF00D → RW=1, mem_wdata=0xCAFEF00D held through BUSY, dm_done pulse, rdata unchanged.
- reset=0 asserted in the 2nd BUSY cycle → next cycle memEnable=0, state IDLE, no done; with req still high, BUSY is re-entered one cycle after reset=1.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=15, MOC never asserted → dm_done and dm_err pulse at BUSY cycle 15, rdata=0. MOC on that same edge → err=0.
- Requester inputs changed during BUSY → memory outputs unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester index / owner encoding (also the bit position in 2-wide masks)
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int NUM_REQ = 2;

  // One-hot mask for an owner, bit 0 = fetch, bit 1 = data
  function automatic logic [NUM_REQ-1:0] own_mask(input logic own);
    return own ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// slave  : arbiter view
// master : environment view (requesters + memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req,    dm_req;
  logic              if_rw,     dm_rw;
  logic [1:0]        if_size,   dm_size;
  logic [ADDR_W-1:0] if_addr,   dm_addr;
  logic [DATA_W-1:0] if_wdata,  dm_wdata;
  logic              if_grant,  dm_grant;
  logic              if_done,   dm_done;
  logic              if_err,    dm_err;
  logic [DATA_W-1:0] rdata;
  logic              memEnable;
  logic              RW;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              MOC;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, dm_req, if_rw, dm_rw, if_size, dm_size,
           if_addr, dm_addr, if_wdata, dm_wdata, MOC, mem_rdata,
    output if_grant, dm_grant, if_done, dm_done, if_err, dm_err,
           rdata, memEnable, RW, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output if_req, dm_req, if_rw, dm_rw, if_size, dm_size,
           if_addr, dm_addr, if_wdata, dm_wdata, MOC, mem_rdata,
    input  if_grant, dm_grant, if_done, dm_done, if_err, dm_err,
           rdata, memEnable, RW, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational 2-way round-robin pick. excl masks out the current owner
// while in DONE so the other requester gets the back-to-back slot.
import mem_arb_pkg::*;

module mem_arb_rr_picker (
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_own,
  input  logic [NUM_REQ-1:0] excl,
  output logic               valid,
  output logic               winner
);
  logic [NUM_REQ-1:0] eff;

  // Tie goes to whoever was not granted last; a lone request always wins
  always_comb begin
    eff    = req & ~excl;
    valid  = |eff;
    winner = (&eff) ? ~last_own : eff[OWN_DM];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single memEnable/RW/MOC memory port shared
// by instruction fetch and data load/store.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort transfers that see
// no MOC within TIMEOUT BUSY cycles (done + err, read data forced to 0).
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  state_t                           state;
  logic                             owner;
  logic                             last_own;
  logic                             mem_en;
  logic                             rw_q;
  logic [1:0]                       size_q;
  logic [ADDR_W-1:0]                addr_q;
  logic [DATA_W-1:0]                wdata_q;
  logic [DATA_W-1:0]                rdata_q;
  logic [NUM_REQ-1:0]               grant_q;
  logic [NUM_REQ-1:0]               done_q;

  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               req_rw;
  logic [NUM_REQ-1:0][1:0]          req_size;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata;
  logic [NUM_REQ-1:0]               excl;
  logic                             pick_vld;
  logic                             pick_win;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]                    cnt;
  logic [NUM_REQ-1:0]               err_q;
`endif

  // Pack requester fields so the winner can be selected by index
  always_comb begin
    req       = {bus.dm_req,   bus.if_req};
    req_rw    = {bus.dm_rw,    bus.if_rw};
    req_size  = {bus.dm_size,  bus.if_size};
    req_addr  = {bus.dm_addr,  bus.if_addr};
    req_wdata = {bus.dm_wdata, bus.if_wdata};
    excl      = (state == DONE) ? own_mask(owner) : '0;
  end

  mem_arb_rr_picker u_pick (
    .req      (req),
    .last_own (last_own),
    .excl     (excl),
    .valid    (pick_vld),
    .winner   (pick_win)
  );

  // Port sequencer: IDLE -> BUSY (strobe until MOC) -> DONE (pulse) -> next
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      last_own <= OWN_DM;
      mem_en   <= 1'b0;
      rw_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q  <= '0;
`endif
      case (state)
        IDLE, DONE: begin
          if (pick_vld) begin
            state    <= BUSY;
            owner    <= pick_win;
            last_own <= pick_win;
            mem_en   <= 1'b1;
            rw_q     <= req_rw[pick_win];
            size_q   <= req_size[pick_win];
            addr_q   <= req_addr[pick_win];
            wdata_q  <= req_wdata[pick_win];
            grant_q  <= own_mask(pick_win);
`ifdef MEM_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
          end else begin
            state   <= IDLE;
            grant_q <= '0;
          end
        end
        BUSY: begin
          if (bus.MOC) begin
            state  <= DONE;
            mem_en <= 1'b0;
            done_q <= own_mask(owner);
            if (!rw_q) rdata_q <= bus.mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // cnt holds completed MOC-less BUSY cycles; abort after TIMEOUT of them
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state  <= DONE;
            mem_en <= 1'b0;
            done_q <= own_mask(owner);
            err_q  <= own_mask(owner);
            if (!rw_q) rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.memEnable = mem_en;
  assign bus.RW        = rw_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.if_grant  = grant_q[OWN_IF];
  assign bus.dm_grant  = grant_q[OWN_DM];
  assign bus.if_done   = done_q[OWN_IF];
  assign bus.dm_done   = done_q[OWN_DM];
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.if_err    = err_q[OWN_IF];
  assign bus.dm_err    = err_q[OWN_DM];
`else
  assign bus.if_err    = 1'b0;
  assign bus.dm_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch read, tie after reset,
// back-to-back hand-off, data write with input churn, mid-transfer reset,
// and (watchdog build) timeout abort vs. same-edge MOC.
import mem_arb_pkg::*;

module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time bound");
    $fatal(1, "bench time bound expired");
  end

  initial begin
    reset = 1'b0;
    b.if_req = 0; b.dm_req = 0; b.if_rw = 0; b.dm_rw = 0;
    b.if_size = SZ_WORD; b.dm_size = SZ_WORD;
    b.if_addr = '0; b.dm_addr = '0; b.if_wdata = '0; b.dm_wdata = '0;
    b.MOC = 0; b.mem_rdata = '0;
    tick(); tick();

    // reset state
    chk("rst_en",    64'(b.memEnable), 64'(0));
    chk("rst_rw",    64'(b.RW),        64'(0));
    chk("rst_addr",  64'(b.mem_addr),  64'(0));
    chk("rst_rdata", 64'(b.rdata),     64'(0));
    chk("rst_gnt",   64'({b.if_grant, b.dm_grant}), 64'(0));
    chk("rst_done",  64'({b.if_done, b.dm_done}),   64'(0));
    chk("rst_state", 64'(dut.state),   64'(IDLE));

    // fetch only, MOC in 3rd BUSY cycle
    reset = 1'b1; b.if_req = 1; b.if_addr = 32'h4;
    tick();
    chk("f_en1",   64'(b.memEnable), 64'(1));
    chk("f_gnt",   64'(b.if_grant),  64'(1));
    chk("f_addr",  64'(b.mem_addr),  64'h4);
    chk("f_rw",    64'(b.RW),        64'(0));
    chk("f_size",  64'(b.mem_size),  64'(SZ_WORD));
    tick();
    chk("f_en2",   64'(b.memEnable), 64'(1));
    chk("f_nodone",64'(b.if_done),   64'(0));
    tick();
    chk("f_en3",   64'(b.memEnable), 64'(1));
    b.MOC = 1; b.mem_rdata = 32'h8C220010;
    tick();
    chk("f_en_dn", 64'(b.memEnable), 64'(0));
    chk("f_done",  64'(b.if_done),   64'(1));
    chk("f_gnt_dn",64'(b.if_grant),  64'(1));
    chk("f_rdata", 64'(b.rdata),     64'h8C220010);
    chk("f_err",   64'(b.if_err),    64'(0));
    b.if_req = 0; b.MOC = 0; b.mem_rdata = '0;
    tick();
    chk("f_idle",  64'(dut.state),   64'(IDLE));
    chk("f_done0", 64'(b.if_done),   64'(0));
    chk("f_gnt0",  64'(b.if_grant),  64'(0));

    // simultaneous requests right after reset: fetch first, then data
    reset = 1'b0;
    tick();
    reset = 1'b1; b.if_req = 1; b.dm_req = 1; b.dm_addr = 32'h200;
    tick();
    chk("t_gnt",   64'({b.dm_grant, b.if_grant}), 64'b01);
    chk("t_addr",  64'(b.mem_addr),  64'h4);
    b.MOC = 1; b.mem_rdata = 32'h11112222;
    tick();
    chk("t_done",  64'({b.dm_done, b.if_done}), 64'b01);
    chk("t_rdata", 64'(b.rdata),     64'h11112222);
    b.if_req = 0; b.MOC = 0;
    tick();
    chk("t_b2b",   64'(dut.state),   64'(BUSY));
    chk("t_gnt2",  64'({b.dm_grant, b.if_grant}), 64'b10);
    chk("t_en2",   64'(b.memEnable), 64'(1));
    chk("t_addr2", 64'(b.mem_addr),  64'h200);
    chk("t_last",  64'(dut.last_own), 64'(OWN_DM));
    b.MOC = 1; b.mem_rdata = 32'h33334444;
    tick();
    chk("t_done2", 64'({b.dm_done, b.if_done}), 64'b10);
    chk("t_rdata2",64'(b.rdata),     64'h33334444);
    b.dm_req = 0; b.MOC = 0;
    tick();
    chk("t_idle",  64'(dut.state),   64'(IDLE));

    // data write; requester inputs churn during BUSY
    b.dm_req = 1; b.dm_rw = 1; b.dm_size = SZ_WORD; b.dm_addr = 32'h100;
    b.dm_wdata = 32'hCAFEF00D;
    tick();
    chk("w_rw",    64'(b.RW),        64'(1));
    chk("w_wdata", 64'(b.mem_wdata), 64'hCAFEF00D);
    chk("w_gnt",   64'(b.dm_grant),  64'(1));
    b.dm_wdata = '0; b.dm_addr = 32'hFFF; b.dm_rw = 0; b.dm_size = SZ_BYTE;
    b.mem_rdata = 32'hDEADBEEF;
    tick();
    chk("w_hold_d",64'(b.mem_wdata), 64'hCAFEF00D);
    chk("w_hold_a",64'(b.mem_addr),  64'h100);
    chk("w_hold_r",64'(b.RW),        64'(1));
    chk("w_hold_s",64'(b.mem_size),  64'(SZ_WORD));
    b.MOC = 1;
    tick();
    chk("w_done",  64'(b.dm_done),   64'(1));
    chk("w_rdata", 64'(b.rdata),     64'h33334444);
    b.dm_req = 0; b.MOC = 0;
    tick();

    // owner req ignored in DONE; alternating back-to-back hand-off
    b.if_req = 1; b.if_addr = 32'h8;
    tick();
    chk("a_gnt1",  64'(b.if_grant),  64'(1));
    b.dm_req = 1; b.dm_addr = 32'h204; b.MOC = 1; b.mem_rdata = 32'hA5A5;
    tick();
    chk("a_done1", 64'(b.if_done),   64'(1));
    b.MOC = 0;
    tick();
    chk("a_gnt2",  64'({b.dm_grant, b.if_grant}), 64'b10);
    chk("a_addr2", 64'(b.mem_addr),  64'h204);
    b.MOC = 1; b.mem_rdata = 32'h5A5A;
    tick();
    chk("a_done2", 64'(b.dm_done),   64'(1));
    chk("a_rdata2",64'(b.rdata),     64'h5A5A);
    b.MOC = 0;
    tick();
    chk("a_gnt3",  64'({b.dm_grant, b.if_grant}), 64'b01);
    chk("a_addr3", 64'(b.mem_addr),  64'h8);
    b.dm_req = 0; b.MOC = 1; b.mem_rdata = 32'h77;
    tick();
    chk("a_done3", 64'(b.if_done),   64'(1));
    b.if_req = 0; b.MOC = 0;
    tick();

    // tie with fetch as last owner -> data wins; then reset in 2nd BUSY cycle
    b.if_req = 1; b.dm_req = 1;
    tick();
    chk("r_tie",   64'({b.dm_grant, b.if_grant}), 64'b10);
    tick();
    reset = 1'b0; b.MOC = 1; b.mem_rdata = 32'h99;
    tick();
    chk("r_en",    64'(b.memEnable), 64'(0));
    chk("r_state", 64'(dut.state),   64'(IDLE));
    chk("r_done",  64'({b.dm_done, b.if_done}), 64'b00);
    chk("r_gnt",   64'({b.dm_grant, b.if_grant}), 64'b00);
    chk("r_addr",  64'(b.mem_addr),  64'(0));
    chk("r_rdata", 64'(b.rdata),     64'(0));
    reset = 1'b1; b.MOC = 0;
    tick();
    chk("r_rebusy",64'(b.memEnable), 64'(1));
    chk("r_regnt", 64'({b.dm_grant, b.if_grant}), 64'b01);
    b.MOC = 1; b.mem_rdata = 32'h4242;
    tick();
    chk("r_done2", 64'(b.if_done),   64'(1));
    b.if_req = 0; b.MOC = 0;
    tick();
    chk("r_b2b",   64'(b.dm_grant),  64'(1));
    b.MOC = 1;
    tick();
    chk("r_done3", 64'(b.dm_done),   64'(1));
    b.dm_req = 0; b.MOC = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // no MOC: abort after 15 BUSY cycles with err and zeroed read data
    b.dm_req = 1; b.dm_rw = 0;
    tick();
    repeat (14) tick();
    chk("wd_en15", 64'(b.memEnable), 64'(1));
    chk("wd_nodn", 64'(b.dm_done),   64'(0));
    tick();
    chk("wd_done", 64'(b.dm_done),   64'(1));
    chk("wd_err",  64'(b.dm_err),    64'(1));
    chk("wd_rdata",64'(b.rdata),     64'(0));
    b.dm_req = 0;
    tick();
    // MOC on the expiry edge wins
    b.dm_req = 1;
    tick();
    repeat (14) tick();
    b.MOC = 1; b.mem_rdata = 32'h1234;
    tick();
    chk("wm_done", 64'(b.dm_done),   64'(1));
    chk("wm_err",  64'(b.dm_err),    64'(0));
    chk("wm_rdata",64'(b.rdata),     64'h1234);
    b.dm_req = 0; b.MOC = 0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
